br_stat_ctr: RTL and testbench

BR_STAT_CTR -- requirements
Module: br_stat_ctr

---
 rtl/br_stat_pkg.sv | 29 ++
 rtl/sat_ctr.sv | 36 +++
 rtl/br_stat_ctr.sv | 121 ++++++++++++
 tb/tb_br_stat_ctr.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/br_stat_pkg.sv
// Shared constants for the branch-statistics counter block: register map,
// CTRL/STATUS bit positions and the default counter width.
package br_stat_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  localparam logic [2:0] A_BR_LO    = 3'd0;
  localparam logic [2:0] A_BR_HI    = 3'd1;
  localparam logic [2:0] A_HIT_LO   = 3'd2;
  localparam logic [2:0] A_HIT_HI   = 3'd3;
  localparam logic [2:0] A_MISPR_LO = 3'd4;
  localparam logic [2:0] A_MISPR_HI = 3'd5;
  localparam logic [2:0] A_CTRL     = 3'd6;
  localparam logic [2:0] A_STATUS   = 3'd7;

  localparam int unsigned CTRL_RUN = 0;
  localparam int unsigned CTRL_CLR = 1;
  localparam int unsigned STAT_RUN = 3;

  localparam int unsigned IDX_BR    = 0;
  localparam int unsigned IDX_HIT   = 1;
  localparam int unsigned IDX_MISPR = 2;

  // Upper half of a counter, zero-extended when the counter is narrower than 32.
  function automatic logic [15:0] hi16(input logic [31:0] c);
    return c[31:16];
  endfunction

endpackage

// File: rtl/sat_ctr.sv
// Saturating event counter: holds at all-ones and flags each increment
// attempted while saturated.
module sat_ctr #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic         sat_evt_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         all_ones;

  assign all_ones  = &cnt_q;
  assign sat_evt_o = inc_i & all_ones;
  assign count_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !all_ones)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/br_stat_ctr.sv
// Branch statistics block: three saturating event counters behind a 16-bit
// register interface with HI shadows latched on LO reads.
module br_stat_ctr
  import br_stat_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_br_cnt,
  input  logic        inc_hit_cnt,
  input  logic        inc_mispr_cnt,
  input  logic [2:0]  addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rd_vld
);

  logic             run_q, run_d;
  logic [2:0]       sat_q, sat_d;
  logic [15:0]      shd_q [3];
  logic [15:0]      shd_d [3];
  logic [15:0]      rdata_q, rdata_d;
  logic             rd_vld_q;

  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       inc;
  logic [2:0]       evt;
  logic             wr_ctrl, wr_stat, clr;

  assign inc     = {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} & {3{run_q}};
  assign wr_ctrl = we && (addr == A_CTRL);
  assign wr_stat = we && (addr == A_STATUS);
  assign clr     = wr_ctrl && wdata[CTRL_CLR];

  sat_ctr #(.W(CNT_W)) u_br (
    .clk_i(clk), .rst_i(rst), .inc_i(inc[IDX_BR]), .clr_i(clr),
    .count_o(cnt[IDX_BR]), .sat_evt_o(evt[IDX_BR])
  );

  sat_ctr #(.W(CNT_W)) u_hit (
    .clk_i(clk), .rst_i(rst), .inc_i(inc[IDX_HIT]), .clr_i(clr),
    .count_o(cnt[IDX_HIT]), .sat_evt_o(evt[IDX_HIT])
  );

  sat_ctr #(.W(CNT_W)) u_mispr (
    .clk_i(clk), .rst_i(rst), .inc_i(inc[IDX_MISPR]), .clr_i(clr),
    .count_o(cnt[IDX_MISPR]), .sat_evt_o(evt[IDX_MISPR])
  );

  always_comb begin
    run_d = run_q;
    if (wr_ctrl)
      run_d = wdata[CTRL_RUN];
  end

  // A new saturation event wins over a same-cycle W1C; CLR wins over both.
  always_comb begin
    sat_d = sat_q;
    if (clr)
      sat_d = '0;
    else if (wr_stat)
      sat_d = (sat_q & ~wdata[2:0]) | evt;
    else
      sat_d = sat_q | evt;
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++)
      shd_d[i] = shd_q[i];
    if (clr) begin
      for (int unsigned i = 0; i < 3; i++)
        shd_d[i] = '0;
    end else if (re) begin
      case (addr)
        A_BR_LO:    shd_d[IDX_BR]    = hi16(32'(cnt[IDX_BR]));
        A_HIT_LO:   shd_d[IDX_HIT]   = hi16(32'(cnt[IDX_HIT]));
        A_MISPR_LO: shd_d[IDX_MISPR] = hi16(32'(cnt[IDX_MISPR]));
        default:    ;
      endcase
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      case (addr)
        A_BR_LO:    rdata_d = cnt[IDX_BR][15:0];
        A_BR_HI:    rdata_d = shd_q[IDX_BR];
        A_HIT_LO:   rdata_d = cnt[IDX_HIT][15:0];
        A_HIT_HI:   rdata_d = shd_q[IDX_HIT];
        A_MISPR_LO: rdata_d = cnt[IDX_MISPR][15:0];
        A_MISPR_HI: rdata_d = shd_q[IDX_MISPR];
        A_CTRL:     rdata_d = {15'b0, run_q};
        default:    rdata_d = {12'b0, run_q, sat_q};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      sat_q    <= '0;
      shd_q    <= '{default: '0};
      rdata_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      sat_q    <= sat_d;
      shd_q    <= shd_d;
      rdata_q  <= rdata_d;
      rd_vld_q <= re;
    end
  end

  assign rdata  = rdata_q;
  assign rd_vld = rd_vld_q;

endmodule

// File: tb/tb_br_stat_ctr.sv
// Directed bench for br_stat_ctr: a vector table for basic counting and
// register behaviour, then hand sequences for saturation, CLR and reset.
module tb_br_stat_ctr;
  import br_stat_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inc_br_cnt = 1'b0, inc_hit_cnt = 1'b0, inc_mispr_cnt = 1'b0;
  logic [2:0]  addr = '0;
  logic        re = 1'b0, we = 1'b0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        rd_vld;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [2:0]  inc;
    logic        exp_vld;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t tbl[$];

  br_stat_ctr #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .inc_br_cnt(inc_br_cnt), .inc_hit_cnt(inc_hit_cnt), .inc_mispr_cnt(inc_mispr_cnt),
    .addr(addr), .re(re), .we(we), .wdata(wdata),
    .rdata(rdata), .rd_vld(rd_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic w, input logic r, input logic [2:0] a,
                     input logic [15:0] d, input logic [2:0] i);
    @(negedge clk);
    we = w; re = r; addr = a; wdata = d;
    {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} = i;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [2:0] a, input logic [15:0] exp);
    cyc(1'b0, 1'b1, a, 16'h0, 3'b000);
    check({name, "_vld"}, {15'b0, rd_vld}, 16'h1);
    check(name, rdata, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cyc(1'b1, 1'b0, a, d, 3'b000);
  endtask

  task automatic pulse(input logic [2:0] i, input int unsigned n);
    for (int unsigned k = 0; k < n; k++)
      cyc(1'b0, 1'b0, 3'd0, 16'h0, i);
  endtask

  function automatic void add(input string n, input logic w, input logic r,
                              input logic [2:0] a, input logic [15:0] d, input logic [2:0] i,
                              input logic ev, input logic [15:0] er);
    vec_t v;
    v.name = n; v.we = w; v.re = r; v.addr = a; v.wdata = d; v.inc = i;
    v.exp_vld = ev; v.exp_rdata = er;
    tbl.push_back(v);
  endfunction

  initial begin
    add("wr_ctrl_run",   1, 0, A_CTRL,   16'h0001, 3'b000, 0, 16'h0000);
    for (int k = 0; k < 5; k++)
      add("inc_br",      0, 0, A_BR_LO,  16'h0000, 3'b001, 0, 16'h0000);
    add("rd_br_lo",      0, 1, A_BR_LO,  16'h0000, 3'b000, 1, 16'h0005);
    add("rd_br_hi",      0, 1, A_BR_HI,  16'h0000, 3'b000, 1, 16'h0000);
    add("rd_br_lo2",     0, 1, A_BR_LO,  16'h0000, 3'b000, 1, 16'h0005);
    add("idle_hold",     0, 0, A_BR_LO,  16'h0000, 3'b000, 0, 16'h0005);
    add("wr_lo_ignored", 1, 0, A_BR_LO,  16'h1234, 3'b000, 0, 16'h0005);
    add("rd_br_lo3",     0, 1, A_BR_LO,  16'h0000, 3'b000, 1, 16'h0005);
    add("rd_ctrl",       0, 1, A_CTRL,   16'h0000, 3'b000, 1, 16'h0001);
    add("rd_status",     0, 1, A_STATUS, 16'h0000, 3'b000, 1, 16'h0008);
    add("wr_clr_stop",   1, 0, A_CTRL,   16'h0002, 3'b000, 0, 16'h0008);
    for (int k = 0; k < 10; k++)
      add("inc_stopped", 0, 0, A_BR_LO,  16'h0000, 3'b111, 0, 16'h0008);
    add("rd_br_lo0",     0, 1, A_BR_LO,    16'h0, 3'b000, 1, 16'h0000);
    add("rd_br_hi0",     0, 1, A_BR_HI,    16'h0, 3'b000, 1, 16'h0000);
    add("rd_hit_lo0",    0, 1, A_HIT_LO,   16'h0, 3'b000, 1, 16'h0000);
    add("rd_hit_hi0",    0, 1, A_HIT_HI,   16'h0, 3'b000, 1, 16'h0000);
    add("rd_mispr_lo0",  0, 1, A_MISPR_LO, 16'h0, 3'b000, 1, 16'h0000);
    add("rd_mispr_hi0",  0, 1, A_MISPR_HI, 16'h0, 3'b000, 1, 16'h0000);
    add("rd_ctrl0",      0, 1, A_CTRL,     16'h0, 3'b000, 1, 16'h0000);
    add("rd_status0",    0, 1, A_STATUS,   16'h0, 3'b000, 1, 16'h0000);

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", rdata, 16'h0000);
    check("reset_vld", {15'b0, rd_vld}, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[k]) begin
      cyc(tbl[k].we, tbl[k].re, tbl[k].addr, tbl[k].wdata, tbl[k].inc);
      check({tbl[k].name, "_vld"}, {15'b0, rd_vld}, {15'b0, tbl[k].exp_vld});
      check(tbl[k].name, rdata, tbl[k].exp_rdata);
    end

    // Carry into the upper half and HI shadow stability
    wr(A_CTRL, 16'h0001);
    @(negedge clk);
    force dut.u_br.cnt_q = 32'h0000_FFFF;
    @(posedge clk);
    #1;
    release dut.u_br.cnt_q;
    pulse(3'b001, 1);
    rd("br_lo_carry", A_BR_LO, 16'h0000);
    rd("br_hi_carry", A_BR_HI, 16'h0001);
    pulse(3'b001, 3);
    rd("br_hi_shadow", A_BR_HI, 16'h0001);
    rd("br_lo_after3", A_BR_LO, 16'h0003);
    rd("br_hi_after3", A_BR_HI, 16'h0001);

    // Saturation and sticky flags
    @(negedge clk);
    force dut.u_hit.cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.u_hit.cnt_q;
    pulse(3'b010, 1);
    rd("hit_lo_sat", A_HIT_LO, 16'hFFFF);
    rd("hit_hi_sat", A_HIT_HI, 16'hFFFF);
    rd("status_sat", A_STATUS, 16'h000A);
    wr(A_STATUS, 16'h0002);
    rd("status_w1c", A_STATUS, 16'h0008);
    pulse(3'b010, 1);
    rd("status_resat", A_STATUS, 16'h000A);
    cyc(1'b1, 1'b0, A_STATUS, 16'h0002, 3'b010);
    rd("status_w1c_vs_evt", A_STATUS, 16'h000A);
    rd("hit_lo_still_sat", A_HIT_LO, 16'hFFFF);
    wr(A_STATUS, 16'h0007);
    rd("status_w1c_all", A_STATUS, 16'h0008);

    // Same-cycle read and write of CTRL returns the pre-write value
    cyc(1'b1, 1'b1, A_CTRL, 16'h0000, 3'b000);
    check("ctrl_rw_same_vld", {15'b0, rd_vld}, 16'h1);
    check("ctrl_rw_same", rdata, 16'h0001);
    rd("ctrl_after_rw", A_CTRL, 16'h0000);
    wr(A_CTRL, 16'h0001);

    // CLR beats same-cycle increments; RUN follows wdata[0]
    pulse(3'b100, 2);
    cyc(1'b1, 1'b0, A_CTRL, 16'h0003, 3'b111);
    rd("clr_br_hi", A_BR_HI, 16'h0000);
    rd("clr_hit_hi", A_HIT_HI, 16'h0000);
    rd("clr_br_lo", A_BR_LO, 16'h0000);
    rd("clr_hit_lo", A_HIT_LO, 16'h0000);
    rd("clr_mispr_lo", A_MISPR_LO, 16'h0000);
    rd("clr_status", A_STATUS, 16'h0008);
    rd("clr_ctrl", A_CTRL, 16'h0001);

    // Read coinciding with an increment sees the pre-increment count
    pulse(3'b100, 7);
    cyc(1'b0, 1'b1, A_MISPR_LO, 16'h0000, 3'b100);
    check("mispr_rd_inc_vld", {15'b0, rd_vld}, 16'h1);
    check("mispr_rd_inc", rdata, 16'h0007);
    rd("mispr_rd_next", A_MISPR_LO, 16'h0008);
    pulse(3'b111, 1);
    rd("all_br_lo", A_BR_LO, 16'h0001);
    rd("all_hit_lo", A_HIT_LO, 16'h0001);
    rd("all_mispr_lo", A_MISPR_LO, 16'h0009);

    // Reset during a read suppresses its rd_vld and stops counting
    @(negedge clk);
    re = 1'b1; addr = A_CTRL;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_midread_vld", {15'b0, rd_vld}, 16'h0);
    check("rst_midread_rdata", rdata, 16'h0000);
    @(negedge clk);
    rst = 1'b0; re = 1'b0;
    pulse(3'b111, 3);
    rd("post_rst_br_lo", A_BR_LO, 16'h0000);
    rd("post_rst_mispr_lo", A_MISPR_LO, 16'h0000);
    rd("post_rst_status", A_STATUS, 16'h0000);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'b000);
    check("vld_one_cycle", {15'b0, rd_vld}, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
